// File: rtl/reg_dc_operand_if.sv
// Operand-fetch stage bus: register file snapshot, the decode-side
// instruction handshake, the write-back port and the ALU-side handshake.
//
// Handshake rule, both sides: a transfer happens on a rising clock edge where
// valid and ready are both high. A producer holds valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
interface reg_dc_operand_if #(
    parameter int DW   = 8,
    parameter int NREG = 16,
    parameter int AW   = 4
);
    logic [NREG*DW-1:0] REG_R;
    logic               IN_VALID;
    logic               IN_READY;
    logic [1:0]         SEL;
    logic [AW-1:0]      REG_A_ADDR;
    logic [AW-1:0]      REG_B_ADDR;
    logic [AW-1:0]      REG_O_ADDR;
    logic [DW-1:0]      IM;
    logic               WB_EN;
    logic [AW-1:0]      WB_ADDR;
    logic [DW-1:0]      WB_DATA;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic [DW-1:0]      REG_A;
    logic [DW-1:0]      REG_B;
    logic [AW-1:0]      OUT_O_ADDR;

    // Decode / ALU environment side
    modport master (
        output REG_R, IN_VALID, SEL, REG_A_ADDR, REG_B_ADDR, REG_O_ADDR, IM,
               WB_EN, WB_ADDR, WB_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, REG_A, REG_B, OUT_O_ADDR
    );

    // Operand-fetch stage side
    modport slave (
        input  REG_R, IN_VALID, SEL, REG_A_ADDR, REG_B_ADDR, REG_O_ADDR, IM,
               WB_EN, WB_ADDR, WB_DATA, OUT_READY,
        output IN_READY, OUT_VALID, REG_A, REG_B, OUT_O_ADDR
    );
endinterface

// File: rtl/reg_dc_operand.sv
// reg_dc_operand: operand-fetch stage between decode and the ALU.
// Selects two operands by mode, registers them with the destination address
// behind a valid/ready handshake, and uses a 2-entry skid buffer (output
// register + skid register) so an ALU stall never drops an instruction.
// IN_READY depends on the registered state only.
// Optional feature: define REG_DC_BYPASS_EN to forward write-back data into
// register reads at capture time (modes 00 and 10 only).
// Parameter contract: NREG == 2**AW and DW >= AW.
// dbg_state_o exposes the buffer state: 0 = EMPTY, 1 = ONE, 2 = FULL.
module reg_dc_operand #(
    parameter int DW   = 8,
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic                  CLK_DC,
    input  logic                  RST_N,
    reg_dc_operand_if.slave       bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] out_a_q, out_b_q, skid_a_q, skid_b_q;
    logic [AW-1:0] out_o_q, skid_o_q;

    logic [DW-1:0] ra, rb;
    logic [DW-1:0] cap_a_d, cap_b_d;
    logic          accept, pop;

    assign accept = bus.IN_VALID && (state_q != FULL);
    assign pop    = (state_q != EMPTY) && bus.OUT_READY;

    // Register reads, optionally overridden by a same-cycle write-back
    always_comb begin
        ra = bus.REG_R[bus.REG_A_ADDR*DW +: DW];
        rb = bus.REG_R[bus.REG_B_ADDR*DW +: DW];
`ifdef REG_DC_BYPASS_EN
        if (bus.WB_EN && (bus.WB_ADDR == bus.REG_A_ADDR)) ra = bus.WB_DATA;
        if (bus.WB_EN && (bus.WB_ADDR == bus.REG_B_ADDR)) rb = bus.WB_DATA;
`endif
    end

`ifndef REG_DC_BYPASS_EN
    // Write-back port exists for a uniform interface but has no effect here
    logic unused_wb;
    assign unused_wb = ^{bus.WB_EN, bus.WB_ADDR, bus.WB_DATA};
`endif

    // Operand selection by mode; address modes zero-extend to DW
    always_comb begin
        cap_a_d = '0;
        cap_b_d = '0;
        case (bus.SEL)
            2'b00: begin
                cap_a_d = ra;
                cap_b_d = rb;
            end
            2'b01: cap_a_d = DW'(bus.REG_O_ADDR);
            2'b10: begin
                cap_a_d = ra;
                cap_b_d = bus.IM;
            end
            default: cap_a_d = DW'(bus.REG_B_ADDR);
        endcase
    end

    // Skid-buffer FSM: output register is the FIFO head, skid register the tail
    always_ff @(posedge CLK_DC or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= EMPTY;
            out_a_q  <= '0;
            out_b_q  <= '0;
            out_o_q  <= '0;
            skid_a_q <= '0;
            skid_b_q <= '0;
            skid_o_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_a_q <= cap_a_d;
                        out_b_q <= cap_b_d;
                        out_o_q <= bus.REG_O_ADDR;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_a_q <= cap_a_d;
                        skid_b_q <= cap_b_d;
                        skid_o_q <= bus.REG_O_ADDR;
                        state_q  <= FULL;
                    end else if (accept && pop) begin
                        out_a_q <= cap_a_d;
                        out_b_q <= cap_b_d;
                        out_o_q <= bus.REG_O_ADDR;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_a_q <= skid_a_q;
                        out_b_q <= skid_b_q;
                        out_o_q <= skid_o_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.IN_READY   = (state_q != FULL);
    assign bus.OUT_VALID  = (state_q != EMPTY);
    assign bus.REG_A      = out_a_q;
    assign bus.REG_B      = out_b_q;
    assign bus.OUT_O_ADDR = out_o_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_reg_dc_operand.sv
// Bench for reg_dc_operand: directed cases on an 8-bit/16-register build and
// a randomized FIFO run on a 16-bit/32-register build against a queue model.
module tb_reg_dc_operand;

    logic clk = 1'b0;
    logic rst_n0, rst_n1;
    logic [1:0] dbg0, dbg1;
    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_dc_operand_if #(.DW(8),  .NREG(16), .AW(4)) b0 ();
    reg_dc_operand_if #(.DW(16), .NREG(32), .AW(5)) b1 ();

    reg_dc_operand #(.DW(8), .NREG(16), .AW(4)) u0 (
        .CLK_DC(clk), .RST_N(rst_n0), .bus(b0), .dbg_state_o(dbg0)
    );
    reg_dc_operand #(.DW(16), .NREG(32), .AW(5)) u1 (
        .CLK_DC(clk), .RST_N(rst_n1), .bus(b1), .dbg_state_o(dbg1)
    );

`ifdef REG_DC_BYPASS_EN
    localparam logic [7:0] BYP_EXP = 8'h99;
`else
    localparam logic [7:0] BYP_EXP = 8'h11;
`endif

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  o;
    } ent_t;

    ent_t        q1[$];
    logic [15:0] rf1[32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rf0(input int idx, input logic [7:0] v);
        b0.REG_R[idx*8 +: 8] = v;
    endtask

    task automatic offer0(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] o, input logic [7:0] im);
        b0.IN_VALID   = 1'b1;
        b0.SEL        = sel;
        b0.REG_A_ADDR = a;
        b0.REG_B_ADDR = b;
        b0.REG_O_ADDR = o;
        b0.IM         = im;
    endtask

    task automatic expect0(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] o);
        check({tag, "_valid"}, 32'(b0.OUT_VALID), 32'd1);
        check({tag, "_a"}, 32'(b0.REG_A), 32'(a));
        check({tag, "_b"}, 32'(b0.REG_B), 32'(b));
        check({tag, "_o"}, 32'(b0.OUT_O_ADDR), 32'(o));
    endtask

    // Reference operand selection for the wide build, straight from the mode table
    function automatic ent_t model_op(input logic [1:0] sel, input logic [4:0] a,
                                      input logic [4:0] b, input logic [4:0] o,
                                      input logic [15:0] im, input logic wb_en,
                                      input logic [4:0] wb_addr, input logic [15:0] wb_data);
        ent_t e;
        logic [15:0] va, vb;
        va = rf1[a];
        vb = rf1[b];
`ifdef REG_DC_BYPASS_EN
        if (wb_en && wb_addr == a) va = wb_data;
        if (wb_en && wb_addr == b) vb = wb_data;
`else
        if (wb_en && wb_addr == a && wb_data == 16'hffff) va = rf1[a];
`endif
        e.o = o;
        case (sel)
            2'd0: begin e.a = va; e.b = vb; end
            2'd1: begin e.a = 16'(o); e.b = 16'd0; end
            2'd2: begin e.a = va; e.b = im; end
            default: begin e.a = 16'(b); e.b = 16'd0; end
        endcase
        return e;
    endfunction

    task automatic flatten_rf1();
        for (int i = 0; i < 32; i++) b1.REG_R[i*16 +: 16] = rf1[i];
    endtask

    initial begin
        // Clock/reset block: idle both environments, hold reset
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        b0.REG_R = '0; b0.IN_VALID = 0; b0.SEL = 0; b0.REG_A_ADDR = 0; b0.REG_B_ADDR = 0;
        b0.REG_O_ADDR = 0; b0.IM = 0; b0.WB_EN = 0; b0.WB_ADDR = 0; b0.WB_DATA = 0;
        b0.OUT_READY = 1'b1;
        b1.REG_R = '0; b1.IN_VALID = 0; b1.SEL = 0; b1.REG_A_ADDR = 0; b1.REG_B_ADDR = 0;
        b1.REG_O_ADDR = 0; b1.IM = 0; b1.WB_EN = 0; b1.WB_ADDR = 0; b1.WB_DATA = 0;
        b1.OUT_READY = 1'b1;
        for (int i = 0; i < 32; i++) rf1[i] = 16'd0;
        repeat (3) tick();
        check("rst_valid", 32'(b0.OUT_VALID), 32'd0);
        check("rst_ready", 32'(b0.IN_READY), 32'd1);
        check("rst_a", 32'(b0.REG_A), 32'd0);
        check("rst_b", 32'(b0.REG_B), 32'd0);
        check("rst_o", 32'(b0.OUT_O_ADDR), 32'd0);
        check("rst_state", 32'(dbg0), 32'd0);
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        tick();

        // Operand modes, back-to-back with OUT_READY high
        set_rf0(3, 8'h5A);
        set_rf0(7, 8'hC3);
        offer0(2'b00, 4'd3, 4'd7, 4'd5, 8'h00); tick(); expect0("m00", 8'h5A, 8'hC3, 4'd5);
        offer0(2'b01, 4'd3, 4'd7, 4'hB, 8'h00); tick(); expect0("m01", 8'h0B, 8'h00, 4'hB);
        offer0(2'b10, 4'd3, 4'd7, 4'd4, 8'h80); tick(); expect0("m10", 8'h5A, 8'h80, 4'd4);
        offer0(2'b11, 4'd3, 4'd6, 4'd9, 8'h00); tick(); expect0("m11", 8'h06, 8'h00, 4'd9);
        b0.IN_VALID = 1'b0; tick();
        check("drain_valid", 32'(b0.OUT_VALID), 32'd0);

        // Stall: three offered, two accepted, head held
        b0.OUT_READY = 1'b0;
        offer0(2'b00, 4'd3, 4'd7, 4'd1, 8'h00); tick();
        expect0("st1", 8'h5A, 8'hC3, 4'd1);
        check("st1_ready", 32'(b0.IN_READY), 32'd1);
        offer0(2'b10, 4'd7, 4'd0, 4'd2, 8'h42); tick();
        expect0("st2", 8'h5A, 8'hC3, 4'd1);
        check("st2_ready", 32'(b0.IN_READY), 32'd0);
        check("st2_state", 32'(dbg0), 32'd2);
        offer0(2'b01, 4'd0, 4'd0, 4'd3, 8'h00); tick();
        expect0("st3", 8'h5A, 8'hC3, 4'd1);
        check("st3_ready", 32'(b0.IN_READY), 32'd0);
        b0.IN_VALID = 1'b0;
        b0.OUT_READY = 1'b1; tick();
        expect0("st4", 8'hC3, 8'h42, 4'd2);
        check("st4_ready", 32'(b0.IN_READY), 32'd1);
        tick();
        check("st5_valid", 32'(b0.OUT_VALID), 32'd0);
        check("st5_ready", 32'(b0.IN_READY), 32'd1);

        // Write-back bypass in a register mode and in an address mode
        set_rf0(2, 8'h11);
        b0.WB_EN = 1'b1; b0.WB_ADDR = 4'd2; b0.WB_DATA = 8'h99;
        offer0(2'b00, 4'd2, 4'd7, 4'd6, 8'h00); tick();
        expect0("byp00", BYP_EXP, 8'hC3, 4'd6);
        offer0(2'b11, 4'd2, 4'd2, 4'd6, 8'h00); tick();
        expect0("byp11", 8'h02, 8'h00, 4'd6);
        b0.WB_EN = 1'b0;
        b0.IN_VALID = 1'b0; tick();

        // Asynchronous reset while FULL
        b0.OUT_READY = 1'b0;
        offer0(2'b00, 4'd3, 4'd3, 4'd1, 8'h00); tick();
        offer0(2'b00, 4'd7, 4'd7, 4'd2, 8'h00); tick();
        check("full_state", 32'(dbg0), 32'd2);
        b0.IN_VALID = 1'b0;
        rst_n0 = 1'b0;
        #1;
        check("arst_valid", 32'(b0.OUT_VALID), 32'd0);
        check("arst_ready", 32'(b0.IN_READY), 32'd1);
        #1;
        rst_n0 = 1'b1;
        b0.OUT_READY = 1'b1;
        offer0(2'b00, 4'd7, 4'd3, 4'd8, 8'h00); tick();
        expect0("post_rst", 8'hC3, 8'h5A, 4'd8);
        b0.IN_VALID = 1'b0; tick();

        // Randomized run on the wide build against the queue model
        for (int cyc = 0; cyc < 600; cyc++) begin
            ent_t e;
            logic acc, pp;
            for (int i = 0; i < 32; i++) if ($urandom_range(0, 3) == 0) rf1[i] = 16'($urandom);
            flatten_rf1();
            b1.IN_VALID   = ($urandom_range(0, 7) != 0);
            b1.SEL        = 2'($urandom_range(0, 3));
            b1.REG_A_ADDR = 5'($urandom_range(0, 31));
            b1.REG_B_ADDR = 5'($urandom_range(0, 31));
            b1.REG_O_ADDR = 5'($urandom_range(0, 31));
            b1.IM         = 16'($urandom);
            b1.WB_EN      = ($urandom_range(0, 1) != 0);
            b1.WB_ADDR    = ($urandom_range(0, 1) != 0) ? b1.REG_A_ADDR : 5'($urandom_range(0, 31));
            b1.WB_DATA    = 16'($urandom);
            b1.OUT_READY  = (cyc > 580) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (cyc > 570) b1.IN_VALID = 1'b0;
            acc = b1.IN_VALID && (q1.size() < 2);
            pp  = (q1.size() > 0) && b1.OUT_READY;
            e = model_op(b1.SEL, b1.REG_A_ADDR, b1.REG_B_ADDR, b1.REG_O_ADDR, b1.IM,
                         b1.WB_EN, b1.WB_ADDR, b1.WB_DATA);
            tick();
            if (pp) void'(q1.pop_front());
            if (acc) q1.push_back(e);
            check("rnd_valid", 32'(b1.OUT_VALID), 32'(q1.size() != 0));
            check("rnd_ready", 32'(b1.IN_READY), 32'(q1.size() < 2));
            check("rnd_state", 32'(dbg1), 32'(q1.size()));
            if (q1.size() != 0) begin
                check("rnd_a", 32'(b1.REG_A), 32'(q1[0].a));
                check("rnd_b", 32'(b1.REG_B), 32'(q1[0].b));
                check("rnd_o", 32'(b1.OUT_O_ADDR), 32'(q1[0].o));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_dc_operand.md
# reg_dc_operand

Parametrised operand-fetch stage between instruction decode and the ALU. It selects two DW-bit operands from the flattened register file, the destination address, a source address or the immediate, depending on the operand mode. It registers the result behind a valid/ready handshake with a 2-entry skid buffer so ALU stalls never drop an instruction. An optional write-back bypass resolves read-after-write hazards at capture time.

## Interface
- DW, 8, operand/register width in bits
- NREG, 16, number of registers
- AW, 4, register address width; NREG must equal 2**AW and DW must be >= AW
- CLK_DC  in  1  clock; all state changes on its rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REG_R  in  NREG*DW  flattened register file; register i at bits [i*DW +: DW]
- IN_VALID  in  1  decode presents an instruction
- IN_READY  out  1  stage can accept
- SEL  in  2  operand mode
- REG_A_ADDR, REG_B_ADDR, REG_O_ADDR  in  AW each  source A, source B and destination addresses
- IM  in  DW  immediate
- WB_EN  in  1  write-back strobe
- WB_ADDR  in  AW  write-back address
- WB_DATA  in  DW  write-back data
- OUT_VALID  out  1  operands valid
- OUT_READY  in  1  ALU accepts
- REG_A, REG_B  out  DW each  operands
- OUT_O_ADDR  out  AW  destination address carried with the operands

## Operation
- Accept occurs when IN_VALID && IN_READY. Capture occurs at the accept edge. Read values are RA = REG_R[REG_A_ADDR], RB = REG_R[REG_B_ADDR].
- Operand modes:
  - SEL=00: A=RA, B=RB.
  - SEL=01: A=zero-extended REG_O_ADDR, B=0.
  - SEL=10: A=RA, B=IM.
  - SEL=11: A=zero-extended REG_B_ADDR, B=0.
- OUT_O_ADDR is always REG_O_ADDR.
- Buffer FSM uses three states: EMPTY, ONE (output register valid), FULL (output register plus skid register valid).
  - EMPTY: an accept moves to ONE.
  - ONE:
    - Accept with no pop: move to FULL; the new entry goes to the skid register.
    - Pop with no accept: move to EMPTY.
    - Accept and pop together: stay in ONE; the new entry goes to the output register.
  - FULL: a pop moves the skid register into the output register and goes to ONE. No accept is possible in FULL.
- Pop occurs when OUT_VALID && OUT_READY.
- IN_READY = (state != FULL), decoded from registered state only. There is no combinational path from OUT_READY.
- While OUT_VALID && !OUT_READY, REG_A, REG_B and OUT_O_ADDR are held stable.
- Ordering is strictly FIFO.
- Operands are sampled only at accept. Buffered entries are not refreshed by later write-backs.

## Timing
- Latency is 1 cycle: an accept at edge N gives OUT_VALID high after edge N.
- Throughput is 1 instruction per cycle while OUT_READY stays high.
- Reset values: OUT_VALID=0, REG_A=0, REG_B=0, OUT_O_ADDR=0, state EMPTY, IN_READY=1.
- RST_N assertion mid-operation discards both entries immediately, without waiting for a clock edge.
- Accept and pop in the same cycle in ONE is legal and keeps OUT_VALID high.
- IN_VALID while IN_READY=0 is ignored; decode must hold its inputs.

## Configuration
- REG_DC_BYPASS_EN defined:
  - At capture, if WB_EN && WB_ADDR==REG_A_ADDR, RA=WB_DATA.
  - Likewise, if WB_EN && WB_ADDR==REG_B_ADDR, RB=WB_DATA.
  - Bypass applies only to the modes that read registers (00, 10).
- REG_DC_BYPASS_EN undefined: WB_* ports are present but ignored, and RA/RB come from REG_R only.

## Test plan
- Reset, then SEL=00 with r3=0x5A, r7=0xC3, A_ADDR=3, B_ADDR=7, OUT_READY=1 -> next cycle OUT_VALID=1, REG_A=0x5A, REG_B=0xC3.
- SEL=01 with O_ADDR=0xB -> REG_A=0x0B, REG_B=0. SEL=10 with IM=0x80 -> REG_B=0x80. SEL=11 with B_ADDR=0x6 -> REG_A=0x06, REG_B=0.
- OUT_READY=0 while three instructions are offered -> two are accepted, IN_READY=0 after the second accept, outputs stay at the first instruction. Then raise OUT_READY -> both emerge in order, IN_READY returns to 1.
- Bypass: r2=0x11 with WB_EN=1, WB_ADDR=2, WB_DATA=0x99 in the accept cycle -> REG_A=0x99 with macro defined, 0x11 without.
- RST_N pulsed low while FULL -> OUT_VALID=0 and IN_READY=1 without a clock edge; after release, the first accept yields fresh data.
- DW=16, NREG=32 build with back-to-back accepts and random OUT_READY -> output sequence matches a reference-model FIFO with no loss or duplication.
